mem_stage: RTL

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM register and the MEM/WB boundary. It consumes the registered EX/MEM fields and performs loads and stores against a data memory with a req/ack handshake. Sub-word data is aligned and extended, and the result is registered into the MEM/WB outputs. It asserts a stall to the hazard unit while a memory access is outstanding, and squashes misaligned accesses.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mem_align.sv | 76 +++++++
 rtl/mem_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, MEM-stage FSM states and access sizes.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } mem_size_e;

endpackage

// File: rtl/mem_align.sv
// Access-size decode, byte enables, store-lane replication and load extraction/extension.
// Subword support is built only when MEM_SUBWORD_EN is defined; otherwise all accesses are words.
module mem_align
  import mips_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] mb_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misal_o
);

`ifdef MEM_SUBWORD_EN
  mem_size_e   size;
  logic        sext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    size = SZ_W;
    sext = 1'b0;
    case (op_i)
      OP_LB:         begin size = SZ_B; sext = 1'b1; end
      OP_LBU, OP_SB: size = SZ_B;
      OP_LH:         begin size = SZ_H; sext = 1'b1; end
      OP_LHU, OP_SH: size = SZ_H;
      default:       size = SZ_W;
    endcase
  end

  always_comb begin
    byte_v = rdata_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_v = rdata_i[7:0];
      2'd1: byte_v = rdata_i[15:8];
      2'd2: byte_v = rdata_i[23:16];
      2'd3: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o    = 4'hF;
    wdata_o = mb_i;
    ldata_o = rdata_i;
    misal_o = |addr_lo_i;
    case (size)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{mb_i[7:0]}};
        ldata_o = {{24{sext & byte_v[7]}}, byte_v};
        misal_o = 1'b0;
      end
      SZ_H: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{mb_i[15:0]}};
        ldata_o = {{16{sext & half_v[15]}}, half_v};
        misal_o = addr_lo_i[0];
      end
      default: ;
    endcase
  end
`else
  logic unused_op;

  assign unused_op = ^op_i;
  assign be_o      = 4'hF;
  assign wdata_o   = mb_i;
  assign ldata_o   = rdata_i;
  assign misal_o   = |addr_lo_i;
`endif

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory req/ack handshake, stall generation, misalignment squash, MEM/WB regs.
// Subword loads/stores are enabled by defining MEM_SUBWORD_EN.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic              mwmem,
  input  logic [31:0]       minstr,
  input  logic [31:0]       C_r,
  input  logic [31:0]       mb,
  input  logic [4:0]        mrn,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack,
  output logic              mstall,
  output logic              mexc,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [31:0]       wmo,
  output logic [31:0]       walu,
  output logic [4:0]        wrn,
  output logic [31:0]       winstr
);

  mem_state_e  state_q, state_d;
  logic        access, misal_raw, mis, pending;
  logic [31:0] ldata;

  logic        wwreg_q, wm2reg_q, mexc_q;
  logic [31:0] wmo_q, walu_q, winstr_q;
  logic [4:0]  wrn_q;

  mem_align u_align (
    .op_i      (minstr[31:26]),
    .addr_lo_i (C_r[1:0]),
    .mb_i      (mb),
    .rdata_i   (dm_rdata),
    .be_o      (dm_be),
    .wdata_o   (dm_wdata),
    .ldata_o   (ldata),
    .misal_o   (misal_raw)
  );

  assign access  = mm2reg | mwmem;
  assign mis     = access & misal_raw;
  // Gating with rst drops the request in the same cycle a reset abandons an access.
  assign pending = access & ~misal_raw & ~rst;

  assign dm_req  = pending;
  assign dm_we   = mwmem;
  assign dm_addr = {C_r[ADDR_W-1:2], 2'b00};
  assign mstall  = pending & ~dm_ack;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MEM_IDLE: if (pending && !dm_ack) state_d = MEM_WAIT;
      MEM_WAIT: if (dm_ack) state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MEM_IDLE;
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      mexc_q   <= 1'b0;
      wmo_q    <= '0;
      walu_q   <= '0;
      wrn_q    <= '0;
      winstr_q <= '0;
    end else begin
      state_q <= state_d;
      mexc_q  <= mis;
      if (mstall) begin
        wwreg_q  <= 1'b0;
        wm2reg_q <= 1'b0;
        winstr_q <= '0;
      end else begin
        wwreg_q  <= mwreg & ~mis;
        wm2reg_q <= mm2reg & ~mis;
        walu_q   <= C_r;
        wrn_q    <= mrn;
        winstr_q <= minstr;
        if (mm2reg && !mis) wmo_q <= ldata;
      end
    end
  end

  assign wwreg  = wwreg_q;
  assign wm2reg = wm2reg_q;
  assign mexc   = mexc_q;
  assign wmo    = wmo_q;
  assign walu   = walu_q;
  assign wrn    = wrn_q;
  assign winstr = winstr_q;

endmodule
